// File: rtl/mole_spawn_scheduler.sv
// Mole spawn scheduler: picks when, where (one of 16 cells) and for how long a mole is up.
// Latency: every output is registered, so a decision is visible one cycle after the state change.
// Backpressure: none; a mole stays up until it is hit, times out, or iEnable drops.
module mole_spawn_scheduler #(
  parameter int          MS_DIV = 50000,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iEnable,
  input  logic [2:0] iLevel,
  input  logic       iHit,
  output logic [3:0] oCell,
  output logic       oPlace,
  output logic       oActive,
  output logic       oMiss,
  output logic [7:0] oMissCount
);

  localparam int PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_UP   = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] lfsr_q;
  logic [PW-1:0] presc_q;
  logic [9:0]  ms_q;
  logic [2:0]  level_q;
  logic [2:0]  level_eff;
  logic [9:0]  life_ms;
  logic [9:0]  dur_ms;
  logic        tick;
  logic        expire;
  logic        entry;
  logic        place_d;
  logic        miss_d;
  logic        active_d;
  logic [3:0]  cand;
  logic [3:0]  cell_d;

  // Clamp the requested level into 1..5 and derive the current state's duration.
  always_comb begin
    level_eff = iLevel;
    if (iLevel == 3'd0) level_eff = 3'd1;
    else if (iLevel > 3'd5) level_eff = 3'd5;

    case (level_q)
      3'd1:    life_ms = 10'd1000;
      3'd2:    life_ms = 10'd800;
      3'd3:    life_ms = 10'd600;
      3'd4:    life_ms = 10'd400;
      default: life_ms = 10'd200;
    endcase

    // The gap is always half the lifetime at the same level.
    dur_ms = (state_q == S_UP) ? life_ms : {1'b0, life_ms[9:1]};
    tick   = (presc_q == PW'(MS_DIV - 1));
    expire = tick && (ms_q == dur_ms - 10'd1);
    entry  = (state_d != state_q);
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; dropping iEnable beats everything, and a hit beats a timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (iEnable) state_d = S_GAP;
      S_GAP: begin
        if (!iEnable)    state_d = S_IDLE;
        else if (expire) state_d = S_UP;
      end
      S_UP: begin
        if (!iEnable)    state_d = S_IDLE;
        else if (iHit)   state_d = S_GAP;
        else if (expire) state_d = S_GAP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; the new cell skips the current one so a mole never reappears in place.
  always_comb begin
    place_d  = (state_q == S_GAP) && (state_d == S_UP);
    miss_d   = (state_q == S_UP) && iEnable && !iHit && expire;
    active_d = (state_d == S_UP);
    cand     = lfsr_q[3:0];
    cell_d   = oCell;
    if (place_d) cell_d = (cand == oCell) ? cand + 4'd1 : cand;
  end

  // Registered outputs, including the saturating miss counter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      oCell      <= 4'd0;
      oPlace     <= 1'b0;
      oActive    <= 1'b0;
      oMiss      <= 1'b0;
      oMissCount <= 8'd0;
    end else begin
      oCell   <= cell_d;
      oPlace  <= place_d;
      oActive <= active_d;
      oMiss   <= miss_d;
      if (miss_d && (oMissCount != 8'hFF)) oMissCount <= oMissCount + 8'd1;
    end
  end

  // Millisecond timer restarts on every state entry so each state measures from its first cycle.
  always_ff @(posedge Clock) begin
    if (Reset || entry) begin
      presc_q <= '0;
      ms_q    <= 10'd0;
    end else if (tick) begin
      presc_q <= '0;
      ms_q    <= ms_q + 10'd1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // Level is frozen at state entry so mid-state changes only affect the next state.
  always_ff @(posedge Clock) begin
    if (Reset)      level_q <= 3'd1;
    else if (entry) level_q <= level_eff;
  end

  // Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge Clock) begin
    if (Reset) lfsr_q <= SEED;
    else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

endmodule

// File: doc/mole_spawn_scheduler.md
# mole_spawn_scheduler

Mole spawn scheduler for the whack-a-mole game: decides when a mole appears, in which of the 16 board cells, and how long it stays up, based on the difficulty level. Sits directly upstream of the mole board. It drives the board's place-mole cell number and place strobe, and takes the board's hit flag back. It also reports misses (moles that expire unhit) to the score/LCD logic.

## Interface
- MS_DIV, default 50000: Clock cycles per millisecond tick (50 MHz board). Benches use 4.
- SEED, default 16'hACE1: LFSR reset value; must be nonzero.
- Clock  input  1  system clock, 50 MHz.
- Reset  input  1  synchronous, active-high.
- iEnable  input  1  game running. Low forces IDLE.
- iLevel  input  3  difficulty 1..5; 0 is treated as 1, 6..7 are treated as 5.
- iHit  input  1  board hit flag; sampled only in UP.
- oCell  output  4  cell of the current/last mole; held stable outside place events.
- oPlace  output  1  one-cycle strobe: a new mole is placed at oCell.
- oActive  output  1  a mole is currently up.
- oMiss  output  1  one-cycle strobe: a mole expired without being hit.
- oMissCount  output  8  saturating count of misses.

## Operation
- Reset values: state IDLE, oCell 0, oPlace 0, oActive 0, oMiss 0, oMissCount 0, lfsr SEED, prescaler 0, ms counter 0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; feedback = l[15]^l[13]^l[12]^l[10], shifted into bit 0. Free-running every cycle when not in Reset, in all states.
- Effective level L = clamp(iLevel, 1, 5), latched on every state entry.
- Lifetime in UP: life_ms = 1200 − 200·L (1000, 800, 600, 400, 200).
- GAP duration: gap_ms = life_ms/2.
- States:
  - IDLE: oActive 0. When iEnable is 1, go to GAP next cycle.
  - GAP: wait gap_ms. On expiry, go to UP.
  - UP: oActive 1. Exits on hit (to GAP), on timeout (to GAP), or on iEnable low (to IDLE).
- iEnable low in any state: IDLE next cycle. oActive clears and no oMiss is issued.
- Cell selection on GAP→UP: candidate c = lfsr[3:0]. If c equals the current oCell, use c+1 mod 16 (16'hF+1 wraps to 0). This guarantees no immediate repeat.
- Hit and timeout asserted in the same cycle: the hit wins; no oMiss, no count increment.
- iHit in IDLE or GAP is ignored.
- oMissCount increments on each oMiss and saturates at 255.
- Reset mid-UP returns all outputs to reset values the next cycle. No oMiss is issued.

## Timing
- Millisecond timer:
  - The prescaler counts 0..MS_DIV−1; a tick occurs when it equals MS_DIV−1.
  - The ms counter increments on each tick.
  - Both counters clear on every state entry.
  - A state of duration D ms expires on the cycle where the ms counter is D−1 and a tick occurs.
  - Therefore exactly D·MS_DIV cycles are spent in GAP or UP.
- GAP expiry cycle N: at cycle N+1, state is UP, oActive 1, oPlace 1 for that one cycle, and oCell is updated.
- iHit high at cycle N in UP: at N+1, state is GAP and oActive is 0.
- UP timeout at cycle N without hit: at N+1, oMiss 1 (one cycle), oMissCount +1, oActive 0, state GAP.
- All outputs are registered. There is no combinational path from input to output.

## Test plan
- Reset: assert Reset with iEnable 1 -> all outputs 0. Release Reset -> GAP starts; with MS_DIV=4 and L=1, oPlace pulses exactly 2000 cycles after the first GAP cycle, and oActive goes 1 on the same cycle.
- Timeout/miss: L=5, no hit -> oActive stays high for exactly 800 cycles, then one oMiss pulse and oMissCount = 1. Repeat 300 moles -> oMissCount stays at 255.
- Hit: iHit pulses 10 cycles into UP -> oActive drops the next cycle, no oMiss. The next oPlace occurs after the gap (400 cycles at L=5).
- Hit coincides with timeout: iHit on the expiry cycle -> no oMiss, oMissCount unchanged.
- Level clamp: iLevel=0 -> UP lasts 4000 cycles; iLevel=7 -> UP lasts 800 cycles. Changing iLevel mid-UP does not alter the current UP duration.
- Cell rules: over 1000 placements, no two consecutive oCell values are equal and all 16 cells appear. Drop iEnable mid-UP -> IDLE next cycle, oActive 0, no oMiss.
